mem_wb_skid_stage: RTL
======================

# mem_wb_skid_stage

Parametrised MEM→WB pipeline boundary that replaces the fixed, always-advancing MEM/WB register with a valid/ready handshake stage. Has a two-entry skid buffer, synchronous flush and a write-back data mux. Sits between the data-memory stage and the register-file write port. Lets a multi-cycle memory or a stalled write-back port back-pressure the pipeline without losing an instruction. Full throughput is one instruction per cycle; `in_ready` is fully registered.

## Interface
- `DATA_W`, 32, width of the load data and ALU-result/address fields
- `REG_AW`, 5, width of the destination register index
- `SUPPRESS_R0`, 1, when 1 a write to register index 0 is presented with `out_regwrite`=0
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `flush`  in  1  synchronous; discard all held entries and any same-cycle input
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  stage can accept; registered (equals NOT skid_valid)
- `in_regwrite`  in  1  instruction writes the register file
- `in_memtoreg`  in  1  write-back source: 1 = load data, 0 = address/ALU result
- `in_readdata`  in  DATA_W  data-memory read data
- `in_address`  in  DATA_W  ALU result / memory address
- `in_rd`  in  REG_AW  destination register index
- `out_valid`  out  1  WB entry valid
- `out_ready`  in  1  write-back port consumes the entry this cycle
- `out_regwrite`  out  1  `main_regwrite` AND `out_valid` AND NOT (`SUPPRESS_R0` AND `out_rd`==0)
- `out_memtoreg`, `out_readdata`, `out_address`, `out_rd`  out  1/DATA_W/DATA_W/REG_AW  fields of the main entry
- `out_wbdata`  out  DATA_W  combinational: `out_memtoreg` ? `out_readdata` : `out_address`
- `occupancy`  out  2  number of held entries, 0..2

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit and a full field copy.
- `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Main empty, `in_fire`: input loads main.
- Main full, `out_fire`, no `in_fire`:
  - skid valid → skid moves to main, skid clears;
  - otherwise main clears.
- Main full, `out_fire` and `in_fire` (skid necessarily empty): input loads main.
- Main full, no `out_fire`, `in_fire`: input loads skid; `in_ready` drops next cycle.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- Flush:
  - both valid bits clear at the next edge; any `in_fire` in that cycle is discarded;
  - `out_fire` in the flush cycle still counts as a completed write, so the WB port may write it;
  - flush has priority over every other event.
- Data fields of invalid entries are don't-care, but must not reach `out_regwrite` (it is gated by `out_valid`).
- `occupancy` = main_valid + skid_valid.

## Timing
- Reset (async assert, released sync to `clock`):
  - `out_valid`=0, `out_regwrite`=0, `out_memtoreg`=0, `out_readdata`=0, `out_address`=0, `out_rd`=0, `out_wbdata`=0;
  - `occupancy`=0, `in_ready`=1.
- Reset mid-operation drops all held entries immediately, without waiting for a clock edge.
- Latency: `in_fire` at edge N → `out_valid`=1 with those fields after edge N.
- Throughput: with `out_ready` held 1, one instruction per cycle and `in_ready` stays 1.
- `in_ready` depends only on state, never combinationally on `out_ready`. The skid entry absorbs the one in-flight transfer.
- After a stall with `occupancy`=2:
  - first `out_fire` → skid promotes, `in_ready`=1 the next cycle;
  - a second `out_fire` in that next cycle may coincide with `in_fire`.
- Flush with `occupancy`=2 → `occupancy`=0 and `in_ready`=1 after one edge.

## Test plan
- Reset during traffic: load 2 entries, assert `reset` between edges → all outputs 0 and `in_ready`=1 immediately, `occupancy`=0.
- Streaming: `out_ready`=1, send rd=1..8 with address=0x10·rd, `in_memtoreg`=0 → each appears one cycle later, `out_wbdata`=0x10·rd, `occupancy` never exceeds 1.
- Back-pressure: `out_ready`=0, send A (rd=3, readdata=0xDEAD, memtoreg=1) then B (rd=4) → `occupancy`=2, `in_ready`=0, C held off. Then `out_ready`=1 → A, B, C emerge in order; A has `out_wbdata`=0xDEAD.
- R0 suppression: regwrite=1, rd=0 → `out_valid`=1, `out_regwrite`=0. Repeat with `SUPPRESS_R0`=0 → `out_regwrite`=1.
- Flush: `occupancy`=2 plus `in_fire` and flush in the same cycle → next cycle `out_valid`=0, `occupancy`=0, no flushed rd appears later.
- Simultaneous: `occupancy`=1, `in_fire` and `out_fire` in the same cycle → `occupancy` stays 1 and the new entry is on the outputs.

Source files
------------

// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB handshake bundle: the upstream valid/ready pair with the instruction fields,
// and the downstream write-back entry. The stage connects to the slave modport.
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [DATA_W-1:0] in_readdata;
  logic [DATA_W-1:0] in_address;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic              out_memtoreg;
  logic [DATA_W-1:0] out_readdata;
  logic [DATA_W-1:0] out_address;
  logic [REG_AW-1:0] out_rd;
  logic [DATA_W-1:0] out_wbdata;

  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_readdata, in_address, in_rd, out_ready,
    output in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_address,
           out_rd, out_wbdata
  );

  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_readdata, in_address, in_rd, out_ready,
    input  in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_address,
           out_rd, out_wbdata
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready handshake, a two-entry skid buffer,
// synchronous flush and the write-back data mux. in_ready is taken straight from state.
module mem_wb_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int SUPPRESS_R0 = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  mem_wb_skid_stage_if.slave         bus,
  output logic [1:0]                 occupancy
);
  localparam int ENTRY_W = 2 + 2 * DATA_W + REG_AW;

  logic               r_main_valid;
  logic               r_skid_valid;
  logic [ENTRY_W-1:0] r_main_entry;
  logic [ENTRY_W-1:0] r_skid_entry;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [ENTRY_W-1:0] w_in_entry;
  logic               w_main_regwrite;
  logic               w_main_memtoreg;
  logic [DATA_W-1:0]  w_main_readdata;
  logic [DATA_W-1:0]  w_main_address;
  logic [REG_AW-1:0]  w_main_rd;
  logic               w_rd_is_r0;

  assign w_in_entry = {bus.in_regwrite, bus.in_memtoreg, bus.in_readdata, bus.in_address, bus.in_rd};
  assign {w_main_regwrite, w_main_memtoreg, w_main_readdata, w_main_address, w_main_rd} = r_main_entry;

  assign bus.in_ready = ~r_skid_valid;
  assign w_in_fire    = bus.in_valid & ~r_skid_valid;
  assign w_out_fire   = r_main_valid & bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_entry <= '0;
      r_skid_entry <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      // Main is free this cycle: the skid entry is older than any new input, so it goes first.
      // While skid is occupied in_ready is low, so no input can be lost here.
      if (r_skid_valid) begin
        r_main_entry <= r_skid_entry;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_entry <= w_in_entry;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_entry <= w_in_entry;
      r_skid_valid <= 1'b1;
    end
  end

  assign w_rd_is_r0 = (SUPPRESS_R0 != 0) && (w_main_rd == '0);

  assign bus.out_valid    = r_main_valid;
  assign bus.out_regwrite = w_main_regwrite & r_main_valid & ~w_rd_is_r0;
  assign bus.out_memtoreg = w_main_memtoreg;
  assign bus.out_readdata = w_main_readdata;
  assign bus.out_address  = w_main_address;
  assign bus.out_rd       = w_main_rd;
  assign bus.out_wbdata   = w_main_memtoreg ? w_main_readdata : w_main_address;

  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
endmodule
